// File: rtl/spi_rr_master_if.sv
// Bus bundle for spi_rr_master: requester handshake, response channel and SPI pins.
// The master modport is the controller's view; the slave modport is the view of the
// requesters plus the SPI device on the far side.
interface spi_rr_master_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 8,
    parameter int ID_W   = 1
);
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ*DATA_W-1:0] req_data_i;
    logic [NREQ-1:0]        req_last_i;
    logic [NREQ-1:0]        req_ready_o;
    logic                   rsp_valid_o;
    logic [DATA_W-1:0]      rsp_data_o;
    logic [ID_W-1:0]        rsp_id_o;
    logic                   spi_clk_o;
    logic                   spi_mosi_o;
    logic                   spi_cs_o;
    logic                   spi_miso_i;

    modport master (
        input  req_valid_i, req_data_i, req_last_i, spi_miso_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o,
        output spi_clk_o, spi_mosi_o, spi_cs_o
    );

    modport slave (
        output req_valid_i, req_data_i, req_last_i, spi_miso_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o,
        input  spi_clk_o, spi_mosi_o, spi_cs_o
    );
endinterface

// File: rtl/spi_rr_master.sv
// Shared SPI master (mode 3, MSB first) with round-robin arbitration between NREQ
// byte requesters. A requester that sends a byte with last=0 locks the bus and keeps
// CS low until its last byte.
// Optional feature: define SPI_BURST_TIMEOUT_EN to release a locked burst after TIMEOUT
// idle cycles in WAIT; without it WAIT holds CS low indefinitely.
module spi_rr_master #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int TIMEOUT = 256
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    spi_rr_master_if.master    bus
);
    localparam int IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DivW = $clog2(CLK_DIV) + 1;
    localparam int BitW = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StWait, StHold, StGap} state_e;

    state_e            r_state;
    logic [DivW-1:0]   r_div;
    logic [BitW-1:0]   r_bit;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [IdW-1:0]    r_id;
    logic [IdW-1:0]    r_rr_ptr;
    logic              r_last;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [IdW-1:0]    r_rsp_id;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int ToW = $clog2(TIMEOUT) + 1;
    logic [ToW-1:0]    r_to;
`else
    logic              w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    logic              w_gnt_found;
    logic [IdW-1:0]    w_gnt_id;
    logic [NREQ-1:0]   w_ready;
    logic              w_accept;
    logic [IdW-1:0]    w_sel_id;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        int idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_gnt_found && bus.req_valid_i[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = IdW'(idx);
            end
        end
    end

    // Ready: granted requester in IDLE, only the locked requester in WAIT; forced low in reset.
    always_comb begin
        w_ready = '0;
        if (!sys_rst) begin
            if (r_state == StIdle && w_gnt_found) begin
                w_ready[w_gnt_id] = 1'b1;
            end else if (r_state == StWait && bus.req_valid_i[r_id]) begin
                w_ready[r_id] = 1'b1;
            end
        end
    end

    assign w_accept   = |(w_ready & bus.req_valid_i);
    assign w_sel_id   = (r_state == StWait) ? r_id : w_gnt_id;
    assign w_sel_data = bus.req_data_i[int'(w_sel_id)*DATA_W +: DATA_W];
    assign w_sel_last = bus.req_last_i[w_sel_id];

    // Transfer sequencer: all SPI pins and the response channel are registered here.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= StIdle;
            r_div       <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_id        <= '0;
            r_rr_ptr    <= '0;
            r_last      <= 1'b0;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_cs        <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
`ifdef SPI_BURST_TIMEOUT_EN
            r_to        <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_tx    <= w_sel_data;
                        r_last  <= w_sel_last;
                        r_id    <= w_gnt_id;
                        r_cs    <= 1'b0;
                        r_div   <= '0;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    if (r_div == DivW'(CLK_DIV - 1)) begin
                        r_state <= StShift;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_tx[DATA_W-1];
                        r_tx    <= r_tx << 1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StShift: begin
                    if (r_div == DivW'(CLK_DIV - 1)) begin
                        // Rising SCLK edge: capture MISO.
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[DATA_W-2:0], bus.spi_miso_i};
                        r_div  <= r_div + 1'b1;
                    end else if (r_div == DivW'(2 * CLK_DIV - 1)) begin
                        r_div <= '0;
                        if (r_bit == BitW'(DATA_W - 1)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_rx;
                            r_rsp_id    <= r_id;
                            r_state     <= r_last ? StHold : StWait;
`ifdef SPI_BURST_TIMEOUT_EN
                            r_to        <= '0;
`endif
                        end else begin
                            // Falling SCLK edge: present next MOSI bit.
                            r_bit  <= r_bit + 1'b1;
                            r_sclk <= 1'b0;
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= r_tx << 1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StWait: begin
                    if (w_accept) begin
                        // CS already low: skip setup, first falling edge next cycle.
                        r_tx    <= w_sel_data << 1;
                        r_mosi  <= w_sel_data[DATA_W-1];
                        r_last  <= w_sel_last;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= StShift;
`ifdef SPI_BURST_TIMEOUT_EN
                        r_to    <= '0;
`endif
                    end
`ifdef SPI_BURST_TIMEOUT_EN
                    else if (r_to == ToW'(TIMEOUT - 1)) begin
                        r_state <= StHold;
                        r_div   <= '0;
                    end else begin
                        r_to <= r_to + 1'b1;
                    end
`endif
                end
                StHold: begin
                    if (r_div == DivW'(CLK_DIV - 1)) begin
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_div   <= '0;
                        r_state <= StGap;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StGap: begin
                    if (r_div == DivW'(CLK_DIV - 1)) begin
                        r_div    <= '0;
                        r_rr_ptr <= IdW'((int'(r_id) + 1) % NREQ);
                        r_state  <= StIdle;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_data_o  = r_rsp_data;
    assign bus.rsp_id_o    = r_rsp_id;
    assign bus.spi_clk_o   = r_sclk;
    assign bus.spi_mosi_o  = r_mosi;
    assign bus.spi_cs_o    = r_cs;
endmodule

// File: tb/tb_spi_rr_master.sv
// Self-checking bench for spi_rr_master (NREQ=2, DATA_W=8, CLK_DIV=4, TIMEOUT=16).
module tb_spi_rr_master;
    localparam int NREQ    = 2;
    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 16;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    spi_rr_master_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ID_W(1)) bus ();

    spi_rr_master #(
        .NREQ(NREQ), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // SPI slave: loopback or shifts out pat MSB first, changing on SCLK falling edges.
    bit         loop_mode = 1'b1;
    logic [7:0] pat = 8'h00;
    logic       miso_q = 1'b0;
    logic [2:0] scnt = 3'd7;
    always @(negedge bus.spi_clk_o) begin
        if (!bus.spi_cs_o) begin
            miso_q <= pat[scnt];
            scnt   <= scnt - 3'd1;
        end
    end
    assign bus.spi_miso_i = loop_mode ? bus.spi_mosi_o : miso_q;

    // Bus monitor, sampled on the falling sys_clk edge.
    int cs_low_cnt = 0, cs_rise_cnt = 0, rise_cnt = 0, last_rise_cyc = 0, last_period = 0;
    int rsp_cnt = 0, last_rsp_cyc = 0, rdy0_cnt = 0, hi_run = 0, min_gap = 1000, mosi_bad = 0;
    bit seen_low = 1'b0;
    logic prev_sclk = 1'b1, prev_cs = 1'b1;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] rsp_data_log [64];
    int         rsp_id_log [64];

    always @(negedge sys_clk) begin
        if (!bus.spi_cs_o) begin
            cs_low_cnt++;
            if (prev_cs && seen_low && hi_run < min_gap) min_gap = hi_run;
            seen_low = 1'b1;
            hi_run   = 0;
        end else begin
            hi_run++;
            if (!prev_cs) cs_rise_cnt++;
            if (bus.spi_mosi_o) mosi_bad++;
        end
        if (bus.spi_clk_o && !prev_sclk && !bus.spi_cs_o) begin
            rise_cnt++;
            mosi_sh       = {mosi_sh[6:0], bus.spi_mosi_o};
            last_period   = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
        end
        if (bus.rsp_valid_o) begin
            if (rsp_cnt < 64) begin
                rsp_data_log[rsp_cnt] = bus.rsp_data_o;
                rsp_id_log[rsp_cnt]   = int'(bus.rsp_id_o);
            end
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end
        if (bus.req_ready_o[0]) rdy0_cnt++;
        prev_sclk = bus.spi_clk_o;
        prev_cs   = bus.spi_cs_o;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    // Waits for requester id to be ready; returns after the accepting edge.
    task automatic do_accept(input int id, output int acc_cyc, output bit ok);
        ok = 1'b0;
        acc_cyc = 0;
        #1;
        for (int n = 0; n < 400; n++) begin
            if (bus.req_ready_o[id] && bus.req_valid_i[id]) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge sys_clk);
            #1;
        end
        if (ok) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input int id, input logic [7:0] d, input bit last,
                             output int acc_cyc, output bit ok);
        bus.req_valid_i[id]       = 1'b1;
        bus.req_data_i[id*8 +: 8] = d;
        bus.req_last_i[id]        = last;
        do_accept(id, acc_cyc, ok);
        bus.req_valid_i[id] = 1'b0;
        bus.req_last_i[id]  = 1'b0;
    endtask

    task automatic wait_rsp(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (rsp_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
            #1;
        end
    endtask

    // Both requesters already valid: records the order of the two grants.
    task automatic arb_pair(output int g0, output int g1, output bit ok);
        int got [2];
        bit f;
        int gid;
        ok = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            f   = 1'b0;
            gid = -1;
            for (int n = 0; n < 400; n++) begin
                if ((bus.req_ready_o & bus.req_valid_i) != '0) begin
                    f   = 1'b1;
                    gid = bus.req_ready_o[1] ? 1 : 0;
                    break;
                end
                @(negedge sys_clk);
                #1;
            end
            if (!f) ok = 1'b0;
            else begin
                @(posedge sys_clk);
                #1;
                bus.req_valid_i[gid] = 1'b0;
            end
            got[k] = gid;
        end
        g0 = got[0];
        g1 = got[1];
    endtask

    typedef struct {
        int         id;
        logic [7:0] tx;
        bit         loopb;
        logic [7:0] pat;
        logic [7:0] exp_data;
        int         exp_id;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int acc, acc0, c0, l0, r0, cr, rd0, w, g0, g1, hi_cyc;
        bit ok;

        vecs[0] = '{0, 8'hA5, 1'b1, 8'h00, 8'hA5, 0};
        vecs[1] = '{1, 8'h5A, 1'b1, 8'h00, 8'h5A, 1};
        vecs[2] = '{0, 8'h00, 1'b0, 8'h3C, 8'h3C, 0};
        vecs[3] = '{1, 8'hFF, 1'b0, 8'hC3, 8'hC3, 1};
        vecs[4] = '{0, 8'h81, 1'b1, 8'h00, 8'h81, 0};

        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        sys_rst = 1'b1;
        wait_cycles(3);
        chk("rst_cs", bus.spi_cs_o, 1);
        chk("rst_sclk", bus.spi_clk_o, 1);
        chk("rst_mosi", bus.spi_mosi_o, 0);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_data", bus.rsp_data_o, 0);
        chk("rst_rsp_id", bus.rsp_id_o, 0);
        sys_rst = 1'b0;
        wait_cycles(2);

        // Single-byte transfers from the vector table.
        for (int i = 0; i < 5; i++) begin
            loop_mode = vecs[i].loopb;
            pat       = vecs[i].pat;
            c0 = rsp_cnt;
            l0 = cs_low_cnt;
            r0 = rise_cnt;
            send_byte(vecs[i].id, vecs[i].tx, 1'b1, acc, ok);
            chk($sformatf("v%0d_accept", i), ok, 1);
            wait_rsp(c0 + 1, ok);
            chk($sformatf("v%0d_rsp_seen", i), ok, 1);
            chk($sformatf("v%0d_rsp_data", i), rsp_data_log[c0], vecs[i].exp_data);
            chk($sformatf("v%0d_rsp_id", i), rsp_id_log[c0], vecs[i].exp_id);
            chk($sformatf("v%0d_latency", i), last_rsp_cyc - acc, 69);
            wait_cycles(10);
            chk($sformatf("v%0d_cs_low_cycles", i), cs_low_cnt - l0, 72);
            chk($sformatf("v%0d_sclk_rises", i), rise_cnt - r0, 8);
            chk($sformatf("v%0d_sclk_period", i), last_period, 8);
            chk($sformatf("v%0d_mosi_bits", i), mosi_sh, vecs[i].tx);
        end

        // Round-robin after reset: both valid together, twice.
        loop_mode = 1'b1;
        sys_rst = 1'b1;
        wait_cycles(2);
        sys_rst = 1'b0;
        wait_cycles(2);
        c0 = rsp_cnt;
        bus.req_data_i  = {8'h20, 8'h10};
        bus.req_last_i  = 2'b11;
        bus.req_valid_i = 2'b11;
        arb_pair(g0, g1, ok);
        chk("rr1_done", ok, 1);
        chk("rr1_first", g0, 0);
        chk("rr1_second", g1, 1);
        wait_rsp(c0 + 2, ok);
        chk("rr1_rsp_seen", ok, 1);
        chk("rr1_rsp0_id", rsp_id_log[c0], 0);
        chk("rr1_rsp1_id", rsp_id_log[c0+1], 1);
        chk("rr1_rsp1_data", rsp_data_log[c0+1], 8'h20);
        wait_cycles(10);
        bus.req_data_i  = {8'h40, 8'h30};
        bus.req_valid_i = 2'b11;
        arb_pair(g0, g1, ok);
        chk("rr2_done", ok, 1);
        chk("rr2_first", g0, 0);
        chk("rr2_second", g1, 1);
        wait_rsp(c0 + 4, ok);
        chk("rr2_rsp0_data", rsp_data_log[c0+2], 8'h30);
        bus.req_last_i = 2'b00;
        wait_cycles(10);

        // Burst from req1 while req0 waits.
        c0 = rsp_cnt;
        bus.req_valid_i[1]    = 1'b1;
        bus.req_data_i[15:8]  = 8'h11;
        bus.req_last_i[1]     = 1'b0;
        do_accept(1, acc, ok);
        chk("burst_b0_accept", ok, 1);
        bus.req_valid_i[0]    = 1'b1;
        bus.req_data_i[7:0]   = 8'h44;
        bus.req_last_i[0]     = 1'b1;
        bus.req_data_i[15:8]  = 8'h22;
        cr  = cs_rise_cnt;
        rd0 = rdy0_cnt;
        do_accept(1, acc, ok);
        chk("burst_b1_accept", ok, 1);
        bus.req_data_i[15:8]  = 8'h33;
        bus.req_last_i[1]     = 1'b1;
        do_accept(1, acc, ok);
        chk("burst_b2_accept", ok, 1);
        bus.req_valid_i[1] = 1'b0;
        bus.req_last_i[1]  = 1'b0;
        wait_rsp(c0 + 3, ok);
        chk("burst_rsp_seen", ok, 1);
        chk("burst_cs_continuous", cs_rise_cnt - cr, 0);
        w = last_rsp_cyc;
        do_accept(0, acc0, ok);
        bus.req_valid_i[0] = 1'b0;
        bus.req_last_i[0]  = 1'b0;
        chk("burst_req0_accept", ok, 1);
        chk("burst_req0_after_gap", acc0 - w, 8);
        chk("burst_req0_ready_once", rdy0_cnt - rd0, 1);
        wait_rsp(c0 + 4, ok);
        chk("burst_rsp0", {rsp_data_log[c0], 8'(rsp_id_log[c0])}, {8'h11, 8'h01});
        chk("burst_rsp1", {rsp_data_log[c0+1], 8'(rsp_id_log[c0+1])}, {8'h22, 8'h01});
        chk("burst_rsp2", {rsp_data_log[c0+2], 8'(rsp_id_log[c0+2])}, {8'h33, 8'h01});
        chk("burst_rsp3", {rsp_data_log[c0+3], 8'(rsp_id_log[c0+3])}, {8'h44, 8'h00});
        wait_cycles(10);

        // Burst abandoned after one byte (last=0, valid drops).
        c0 = rsp_cnt;
        send_byte(0, 8'h96, 1'b0, acc, ok);
        chk("wait_accept", ok, 1);
        wait_rsp(c0 + 1, ok);
        chk("wait_rsp_seen", ok, 1);
        w  = last_rsp_cyc;
        cr = cs_rise_cnt;
`ifdef SPI_BURST_TIMEOUT_EN
        hi_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            if (bus.spi_cs_o) begin
                hi_cyc = cyc;
                break;
            end
            @(negedge sys_clk);
            #1;
        end
        chk("timeout_cs_release", hi_cyc - w, 20);
        wait_cycles(100);
        chk("timeout_no_rsp", rsp_cnt - c0, 1);
        chk("timeout_cs_high", bus.spi_cs_o, 1);
`else
        hi_cyc = 0;
        wait_cycles(1000);
        chk("wait_cs_low", bus.spi_cs_o, hi_cyc);
        chk("wait_no_cs_rise", cs_rise_cnt - cr, 0);
        chk("wait_no_rsp", rsp_cnt - c0, 1);
        send_byte(0, 8'h69, 1'b1, acc, ok);
        chk("wait_final_accept", ok, 1);
        wait_rsp(c0 + 2, ok);
        chk("wait_final_data", rsp_data_log[c0+1], 8'h69);
        wait_cycles(10);
        chk("wait_final_cs_high", bus.spi_cs_o, 1);
`endif
        wait_cycles(10);

        // Reset in the middle of SHIFT.
        c0 = rsp_cnt;
        send_byte(0, 8'h5A, 1'b1, acc, ok);
        chk("mid_accept", ok, 1);
        wait_cycles(20);
        chk("mid_pre_cs_low", bus.spi_cs_o, 0);
        bus.req_valid_i[0] = 1'b1;
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_cs", bus.spi_cs_o, 1);
        chk("mid_rst_sclk", bus.spi_clk_o, 1);
        chk("mid_rst_mosi", bus.spi_mosi_o, 0);
        chk("mid_rst_ready", bus.req_ready_o, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
        bus.req_valid_i[0] = 1'b0;
        wait_cycles(2);
        sys_rst = 1'b0;
        wait_cycles(100);
        chk("mid_rst_no_rsp", rsp_cnt - c0, 0);

        chk("cs_gap_min_ge_4", min_gap >= 4, 1);
        chk("mosi_zero_when_cs_high", mosi_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
